// File: rtl/bus_mux_8_1_arb_pkg.sv
// bus_pkg: constants and types shared by the 8:1 arbitrated bus multiplexer.
//   CH_COUNT : number of source channels (8)
//   IDX_W    : width of a channel index (3)
//   state_t  : output-stage state, IDLE (no word held) / HOLD (word held)
package bus_pkg;

  localparam int CH_COUNT = 8;
  localparam int IDX_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/bus_mux_8_1_arb_if.sv
// bus_mux_8_1_arb_if: handshake/data bundle between the eight sources, the
// multiplexer and the downstream consumer.
//   X0..X7 : source data buses (N bits each)
//   req    : per-channel request
//   gnt    : one-hot grant, high in the cycle the granted Xi is sampled
//   Y      : registered output data
//   addr   : channel index of the word on Y
//   valid  : Y/addr hold a word not yet accepted
//   ready  : downstream accepts Y when valid & ready
// Modports: master = sources/consumer side, slave = multiplexer side.
interface bus_mux_8_1_arb_if #(
  parameter int N = 8
);
  import bus_pkg::*;

  logic [N-1:0]          X0, X1, X2, X3, X4, X5, X6, X7;
  logic [CH_COUNT-1:0]   req;
  logic [CH_COUNT-1:0]   gnt;
  logic [N-1:0]          Y;
  logic [IDX_W-1:0]      addr;
  logic                  valid;
  logic                  ready;

  modport master (
    output X0, X1, X2, X3, X4, X5, X6, X7,
    output req, ready,
    input  gnt, Y, addr, valid
  );

  modport slave (
    input  X0, X1, X2, X3, X4, X5, X6, X7,
    input  req, ready,
    output gnt, Y, addr, valid
  );

endinterface

// File: rtl/bus_mux_8_1_arb_rr_arb_8.sv
// rr_arb_8: combinational 8-way round-robin arbiter.
//   req   : per-channel requests
//   ptr   : index of the last granted channel; search starts at ptr+1
//   en    : when low, no grant is issued
//   gnt   : one-hot grant (all-zero when en=0 or req=0)
//   index : binary index of the granted channel (0 when nothing granted)
module rr_arb_8
  import bus_pkg::*;
(
  input  logic [CH_COUNT-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  input  logic                en,
  output logic [CH_COUNT-1:0] gnt,
  output logic [IDX_W-1:0]    index
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk ptr+1, ptr+2, ... ptr+8 (the 3-bit add wraps 7->0); the first
  // requesting channel wins, so ptr itself has the lowest priority.
  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= CH_COUNT; k++) begin
      cand = ptr + IDX_W'(k);
      if (en && !found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        index      = cand;
      end
    end
  end

endmodule

// File: rtl/bus_mux_8_1_arb.sv
// bus_mux_8_1_arb: 8:1 round-robin arbitrated multiplexer with a one-word
// registered output stage and valid/ready handshake.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : bus_mux_8_1_arb_if.slave (X0..X7, req, gnt, Y, addr, valid, ready)
// Parameter N: data bus width.
// Optional macro BUS_MUX_TRISTATE_EN: when defined, Y floats to all-z
// whenever valid=0 (including reset); otherwise Y shows the register.
module bus_mux_8_1_arb
  import bus_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  bus_mux_8_1_arb_if.slave   bus
);

  state_t              state;
  logic [N-1:0]        y_q;
  logic [IDX_W-1:0]    addr_q;
  logic [IDX_W-1:0]    ptr_q;
  logic                valid_q;
  logic                load;
  logic [CH_COUNT-1:0] gnt_w;
  logic [IDX_W-1:0]    gidx;
  logic [N-1:0]        xs [CH_COUNT];

  always_comb begin
    xs[0] = bus.X0;
    xs[1] = bus.X1;
    xs[2] = bus.X2;
    xs[3] = bus.X3;
    xs[4] = bus.X4;
    xs[5] = bus.X5;
    xs[6] = bus.X6;
    xs[7] = bus.X7;
  end

  // A new word may be taken when the stage is empty or is being emptied in
  // this same cycle; rst suppresses the load so gnt stays low during reset.
  assign load = ~rst & (|bus.req) & ((state == IDLE) | bus.ready);

  rr_arb_8 u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .en    (load),
    .gnt   (gnt_w),
    .index (gidx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      y_q     <= '0;
      addr_q  <= '0;
      ptr_q   <= IDX_W'(CH_COUNT - 1);
    end else if (load) begin
      state   <= HOLD;
      valid_q <= 1'b1;
      y_q     <= xs[gidx];
      addr_q  <= gidx;
      ptr_q   <= gidx;
    end else if (state == HOLD && bus.ready) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end
  end

  assign bus.gnt   = gnt_w;
  assign bus.addr  = addr_q;
  assign bus.valid = valid_q;

`ifdef BUS_MUX_TRISTATE_EN
  assign bus.Y = valid_q ? y_q : {N{1'bz}};
`else
  assign bus.Y = y_q;
`endif

endmodule

// File: tb/tb_bus_mux_8_1_arb.sv
// tb_bus_mux_8_1_arb: self-checking bench for bus_mux_8_1_arb.
// Directed vector table, a round-robin sequence after reset, then random
// traffic compared against a behavioural model of the arbitrated stage.
module tb_bus_mux_8_1_arb;
  import bus_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reqIn;
  logic       readyIn;
  logic [N-1:0] xin [8];

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] sampledGnt;
  bit         modelCheck = 0;

  // behavioural model state
  bit         mValid = 0;
  logic [7:0] mY     = '0;
  logic [2:0] mAddr  = '0;
  int         mPtr   = 7;

  always #5 clk = ~clk;

  bus_mux_8_1_arb_if #(.N(N)) bus ();

  assign bus.X0    = xin[0];
  assign bus.X1    = xin[1];
  assign bus.X2    = xin[2];
  assign bus.X3    = xin[3];
  assign bus.X4    = xin[4];
  assign bus.X5    = xin[5];
  assign bus.X6    = xin[6];
  assign bus.X7    = xin[7];
  assign bus.req   = reqIn;
  assign bus.ready = readyIn;

  bus_mux_8_1_arb #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic [7:0] data;
    logic [7:0] expGnt;
    logic       expValid;
    logic [2:0] expAddr;
    logic [7:0] expY;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic r, logic [7:0] rq, logic rdy, logic [7:0] d,
                              logic [7:0] g, logic v, logic [2:0] a, logic [7:0] y);
    vec_t t;
    t.rst = r; t.req = rq; t.ready = rdy; t.data = d;
    t.expGnt = g; t.expValid = v; t.expAddr = a; t.expY = y;
    return t;
  endfunction

  function automatic logic [31:0] expYWord(logic v, logic [7:0] y);
`ifdef BUS_MUX_TRISTATE_EN
    logic [31:0] zw;
    zw = {24'h0, 8'bzzzzzzzz};
    return v ? {24'h0, y} : zw;
`else
    return {24'h0, y};
`endif
  endfunction

  function automatic int pickGrant(logic [7:0] r, int p);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(logic r, logic [7:0] rq, logic rdy, logic [7:0] d);
    rst     = r;
    reqIn   = rq;
    readyIn = rdy;
    for (int i = 0; i < 8; i++) xin[i] = d;
  endtask

  // One clock: sample gnt mid-cycle, optionally compare against the model,
  // advance the model with this cycle's inputs, then move past the edge.
  task automatic step();
    int         g;
    bit         ld;
    logic [7:0] eg;
    @(negedge clk);
    sampledGnt = bus.gnt;
    g  = pickGrant(reqIn, mPtr);
    ld = !rst && (reqIn != 8'h00) && (!mValid || readyIn);
    eg = ld ? 8'(1 << g) : 8'h00;
    if (modelCheck) begin
      checkOutput("model_gnt",   32'(bus.gnt),   32'(eg));
      checkOutput("model_valid", 32'(bus.valid), 32'(mValid));
      checkOutput("model_addr",  32'(bus.addr),  32'(mAddr));
      checkOutput("model_y",     {24'h0, bus.Y}, expYWord(mValid, mY));
    end
    if (rst) begin
      mValid = 0; mY = '0; mAddr = '0; mPtr = 7;
    end else if (ld) begin
      mValid = 1; mY = xin[g]; mAddr = 3'(g); mPtr = g;
    end else if (mValid && readyIn) begin
      mValid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00);

    //            rst  req    rdy  data   gnt    v  addr  Y
    vecs[0]  = mk(1, 8'hFF, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
    vecs[1]  = mk(1, 8'hFF, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00);
    vecs[2]  = mk(0, 8'h08, 0, 8'hA5, 8'h08, 1, 3'd3, 8'hA5);
    vecs[3]  = mk(0, 8'h08, 0, 8'h5A, 8'h00, 1, 3'd3, 8'hA5);
    vecs[4]  = mk(0, 8'h00, 0, 8'h5A, 8'h00, 1, 3'd3, 8'hA5);
    vecs[5]  = mk(0, 8'h02, 0, 8'hC3, 8'h00, 1, 3'd3, 8'hA5);
    vecs[6]  = mk(0, 8'h02, 0, 8'hC3, 8'h00, 1, 3'd3, 8'hA5);
    vecs[7]  = mk(0, 8'h02, 0, 8'hC3, 8'h00, 1, 3'd3, 8'hA5);
    vecs[8]  = mk(0, 8'h02, 1, 8'hC3, 8'h02, 1, 3'd1, 8'hC3);
    vecs[9]  = mk(0, 8'h00, 1, 8'h00, 8'h00, 0, 3'd1, 8'hC3);
    vecs[10] = mk(0, 8'h40, 1, 8'h66, 8'h40, 1, 3'd6, 8'h66);
    vecs[11] = mk(0, 8'h41, 1, 8'h77, 8'h01, 1, 3'd0, 8'h77);
    vecs[12] = mk(0, 8'h40, 1, 8'h88, 8'h40, 1, 3'd6, 8'h88);
    vecs[13] = mk(0, 8'h00, 1, 8'h00, 8'h00, 0, 3'd6, 8'h88);
    vecs[14] = mk(0, 8'h10, 0, 8'h99, 8'h10, 1, 3'd4, 8'h99);
    vecs[15] = mk(1, 8'h10, 0, 8'h99, 8'h00, 0, 3'd0, 8'h00);
    vecs[16] = mk(0, 8'h80, 0, 8'hAB, 8'h80, 1, 3'd7, 8'hAB);
    vecs[17] = mk(0, 8'h00, 1, 8'h00, 8'h00, 0, 3'd7, 8'hAB);

    $display("[TB] directed vectors");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].ready, vecs[i].data);
      step();
      checkOutput($sformatf("vec%0d_gnt", i),   32'(sampledGnt), 32'(vecs[i].expGnt));
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.valid),  32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_addr", i),  32'(bus.addr),   32'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d_y", i),     {24'h0, bus.Y},
                  expYWord(vecs[i].expValid, vecs[i].expY));
    end

    $display("[TB] round-robin after reset");
    applyStimulus(1'b1, 8'hFF, 1'b1, 8'h00);
    step();
    applyStimulus(1'b0, 8'hFF, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) xin[i] = 8'(8'h30 + i);
    for (int k = 0; k < 9; k++) begin
      step();
      checkOutput($sformatf("rr%0d_gnt", k),   32'(sampledGnt), 32'(1 << (k % 8)));
      checkOutput($sformatf("rr%0d_valid", k), 32'(bus.valid),  32'd1);
      checkOutput($sformatf("rr%0d_addr", k),  32'(bus.addr),   32'(k % 8));
      checkOutput($sformatf("rr%0d_y", k),     {24'h0, bus.Y},  32'(8'h30 + (k % 8)));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h00);
    step();

    $display("[TB] random traffic against model");
    modelCheck = 1;
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 39) == 0);
      reqIn   = ($urandom_range(0, 1) == 0) ? 8'($urandom & $urandom) : 8'($urandom);
      readyIn = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) xin[i] = 8'($urandom);
      step();
    end
    modelCheck = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_mux_8_1_arb.md
BUS_MUX_8_1_ARB -- requirements
Module: bus_mux_8_1_arb

Interface
REQ-001 Parameter N, default 8, width in bits of every data bus.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 X0..X7  input  N each  source data buses, channel i on Xi.
REQ-005 req  input  8  req[i]=1: channel i has a word on Xi.
REQ-006 gnt  output  8  one-hot; gnt[i]=1 in the cycle Xi is sampled.
REQ-007 Y  output  N  registered output data bus.
REQ-008 addr  output  3  index of the channel whose word is on Y.
REQ-009 valid  output  1  Y/addr hold a word not yet accepted.
REQ-010 ready  input  1  downstream accepts Y when valid&ready.

Function
REQ-011 SHALL implement states IDLE (no word held) and HOLD (word held, valid=1).
REQ-012 SHALL define load = |req & (state==IDLE | ready); on load, capture the granted Xi into Y, capture i into addr, and enter or stay in HOLD.
REQ-013 SHALL leave HOLD for IDLE when ready=1 and req=0; SHALL stay in HOLD with Y, addr stable when ready=0.
REQ-014 gnt SHALL be combinational from req and the priority pointer; all-zero when load=0; never more than one bit set.
REQ-015 Arbitration SHALL be round-robin: the search starts at ptr+1 mod 8, ptr updates to the granted index on load, wrap 7->0.
REQ-016 Latency: req[i] in IDLE at cycle t -> gnt[i] in cycle t, valid=1 with Y=Xi(t) in cycle t+1.
REQ-017 Back-to-back transfers SHALL incur no bubble: HOLD&ready&|req reloads in the same cycle, giving one word per cycle.
REQ-018 Sources SHALL hold Xi and req[i] until they see gnt[i]; the block SHALL NOT sample Xi in any other cycle.
REQ-019 Deasserting req[i] before gnt SHALL withdraw the request with no side effect.
REQ-020 valid SHALL depend only on state, never combinationally on ready or req.

Reset
REQ-021 On rst=1 at a clock edge: state=IDLE, valid=0, addr=0, ptr=7 (channel 0 first priority), Y=0 (see REQ-024).
REQ-022 rst SHALL override load in the same cycle; a held word is discarded and gnt is forced to 0 while rst=1.

Configuration
REQ-023 Macro BUS_MUX_TRISTATE_EN selects the idle drive of Y.
REQ-024 With BUS_MUX_TRISTATE_EN defined, Y={N{1'bz}} whenever valid=0, including reset; without it, Y keeps its register value (0 after reset) when valid=0.

Structure
REQ-025 Shared package bus_pkg SHALL hold the channel-count constant (8), the index width (3) and the state enum {IDLE, HOLD}.
REQ-026 Arbitration SHALL be a sub-module rr_arb_8 (inputs req, ptr, en; output one-hot gnt, index).

Verification
REQ-027 Reset: rst=1 for 2 cycles with req=8'hFF -> gnt=0, valid=0, addr=0, Y=0 (or z with macro).
REQ-028 Single: IDLE, req=8'h08, X3=8'hA5, ready=0 -> gnt=8'h08 in cycle t; Y=8'hA5, addr=3, valid=1 from t+1; held while ready=0.
REQ-029 Round-robin: req=8'hFF held, ready=1 -> grant order 0,1,...,7,0 with one word per cycle and no bubbles.
REQ-030 Wrap/priority: ptr=6, req=8'h41 -> grant 0 before grant 6 (order 0 then 6).
REQ-031 Backpressure: HOLD, ready=0 for 3 cycles with req=8'h02 -> gnt=0 for those cycles, Y unchanged; ready=1 -> gnt=8'h02 that cycle.
REQ-032 Reset mid-transfer: HOLD with valid=1, rst=1 -> valid=0 next cycle, ptr=7, then req=8'h80 -> channel 7 granted first.
